// File: rtl/dpram_stream_reader.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader
//
// Read-side client for a single-read-port dual-port RAM. A burst command
// (start address, word count) is turned into a sequence of RAM read addresses.
// The RAM's one-cycle read latency is absorbed by a 2-entry skid buffer, and
// the words are emitted on a valid/ready stream with the final word marked.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : burst command handshake
//   cmd_addr, cmd_len     : first word address, number of words (0..MEMD)
//   RAddr                 : RAM read address (registered)
//   RData                 : RAM read data, valid the cycle after RAddr
//   out_valid/out_ready   : output stream handshake
//   out_data, out_last    : output word and last-beat marker
//   busy                  : burst in progress
//   done                  : one-cycle pulse when a burst completes
//   err                   : one-cycle pulse with done for an out-of-range burst
//
// Configuration macro
//   DPRAM_READER_WRAP_EN  : addresses wrap modulo MEMD, lengths clamp to MEMD,
//                           err is never raised. Undefined: bursts running past
//                           the end of the RAM are truncated and flagged.
// -----------------------------------------------------------------------------
module dpram_stream_reader #(
    parameter int MEMD  = 16,
    parameter int DATAW = 32,
    parameter int LENW  = $clog2(MEMD) + 1,
    localparam int AW   = $clog2(MEMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LENW-1:0]  cmd_len,
    output logic [AW-1:0]    RAddr,
    input  logic [DATAW-1:0] RData,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Wide enough to hold address + length without overflow.
    localparam int CW = LENW + 1;
    localparam logic [CW-1:0] MEMD_C = CW'(MEMD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LENW-1:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATAW-1:0]  head_q, head_d;
    logic              head_last_q, head_last_d;
    logic [DATAW-1:0]  tail_q, tail_d;
    logic              tail_last_q, tail_last_d;
    logic              err_pend_q, err_pend_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [LENW-1:0]   eff_len_s;
    logic              bad_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [2:0]        pend_s;
    logic [AW-1:0]     addr_inc_s;

    // Effective burst length and range error for the offered command.
`ifdef DPRAM_READER_WRAP_EN
    logic [CW-1:0] len_ext_s;
    always_comb begin
        len_ext_s = CW'(cmd_len);
        bad_s     = 1'b0;
        if (len_ext_s > MEMD_C) begin
            eff_len_s = LENW'(MEMD);
        end else begin
            eff_len_s = cmd_len;
        end
    end
`else
    logic [CW-1:0] addr_ext_s;
    logic [CW-1:0] len_ext_s;
    logic [CW-1:0] room_s;
    always_comb begin
        addr_ext_s = CW'(cmd_addr);
        len_ext_s  = CW'(cmd_len);
        room_s     = {CW{1'b0}};
        if (addr_ext_s >= MEMD_C) begin
            eff_len_s = {LENW{1'b0}};
            bad_s     = 1'b1;
        end else begin
            room_s = MEMD_C - addr_ext_s;
            if (len_ext_s > room_s) begin
                eff_len_s = LENW'(room_s);
                bad_s     = 1'b1;
            end else begin
                eff_len_s = cmd_len;
                bad_s     = 1'b0;
            end
        end
    end
`endif

    // Next read address after an issue.
`ifdef DPRAM_READER_WRAP_EN
    always_comb begin
        if (addr_q == AW'(MEMD - 1)) begin
            addr_inc_s = {AW{1'b0}};
        end else begin
            addr_inc_s = addr_q + AW'(1);
        end
    end
`else
    always_comb begin
        addr_inc_s = addr_q + AW'(1);
    end
`endif

    // Read issue, skid buffer update and burst FSM next-state.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        occ_d           = occ_q;
        head_d          = head_q;
        head_last_d     = head_last_q;
        tail_d          = tail_q;
        tail_last_d     = tail_last_q;
        err_pend_d      = err_pend_q;
        done_d          = 1'b0;
        err_d           = 1'b0;

        pop_s  = out_valid_q && out_ready;
        push_s = inflight_q;
        pend_s = {1'b0, occ_q} + {2'b00, inflight_q};

        // A read may be issued only if its data is guaranteed a skid slot.
        if (state_q == S_RUN) begin
            if (pend_s < 3'd2) begin
                issue_s = 1'b1;
            end else if ((pend_s == 3'd2) && pop_s) begin
                issue_s = 1'b1;
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
        end

        if (issue_s) begin
            inflight_d      = 1'b1;
            inflight_last_d = (remaining_q == LENW'(1));
            addr_d          = addr_inc_s;
            remaining_d     = remaining_q - LENW'(1);
        end else begin
            inflight_d      = 1'b0;
        end

        // Head register is the stream output; tail only fills while stalled.
        case (occ_q)
            2'd0: begin
                if (push_s) begin
                    head_d      = RData;
                    head_last_d = inflight_last_q;
                    occ_d       = 2'd1;
                end else begin
                    occ_d       = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_d      = RData;
                    head_last_d = inflight_last_q;
                    occ_d       = 2'd1;
                end else if (push_s) begin
                    tail_d      = RData;
                    tail_last_d = inflight_last_q;
                    occ_d       = 2'd2;
                end else if (pop_s) begin
                    occ_d       = 2'd0;
                end else begin
                    occ_d       = 2'd1;
                end
            end
            2'd2: begin
                if (push_s && pop_s) begin
                    head_d      = tail_q;
                    head_last_d = tail_last_q;
                    tail_d      = RData;
                    tail_last_d = inflight_last_q;
                    occ_d       = 2'd2;
                end else if (pop_s) begin
                    head_d      = tail_q;
                    head_last_d = tail_last_q;
                    occ_d       = 2'd1;
                end else begin
                    occ_d       = 2'd2;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    err_pend_d = bad_s;
                    if (eff_len_s == {LENW{1'b0}}) begin
                        // Nothing to read: complete immediately, RAddr untouched.
                        done_d  = 1'b1;
                        err_d   = bad_s;
                        state_d = S_IDLE;
                    end else begin
                        addr_d      = cmd_addr;
                        remaining_d = eff_len_s;
                        state_d     = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s && (remaining_q == LENW'(1))) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Looking at next-cycle occupancy makes done land one cycle
                // after the final beat handshake.
                if ((occ_d == 2'd0) && !inflight_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = err_pend_q;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (occ_d != 2'd0);
        out_last_d  = (occ_d != 2'd0) ? head_last_d : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= {AW{1'b0}};
            remaining_q     <= {LENW{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            head_q          <= {DATAW{1'b0}};
            head_last_q     <= 1'b0;
            tail_q          <= {DATAW{1'b0}};
            tail_last_q     <= 1'b0;
            err_pend_q      <= 1'b0;
            cmd_ready_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            head_q          <= head_d;
            head_last_q     <= head_last_d;
            tail_q          <= tail_d;
            tail_last_q     <= tail_last_d;
            err_pend_q      <= err_pend_d;
            cmd_ready_q     <= cmd_ready_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign RAddr     = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_addr;
    logic [4:0]  cmd_len;
    logic [3:0]  RAddr;
    logic [31:0] RData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;

    logic [31:0] mem [16];
    logic [5:0]  pat;

    dpram_stream_reader #(
        .MEMD  (16),
        .DATAW (32),
        .LENW  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .RAddr     (RAddr),
        .RData     (RData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data for RAddr appears the following cycle.
    always @(posedge clk) begin
        RData <= mem[RAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one burst from a negedge and follow it to done.
    // toggle=0: out_ready held high, exact cycle timing checked.
    // toggle=1: out_ready follows pat, stability and look-ahead checked.
    task automatic run_burst(input string tag, input int addr, input int len,
                             input int exp_n, input logic exp_err, input bit toggle);
        int cyc;
        int beats;
        int ahead;
        logic done_seen;
        logic err_early;
        logic hold_v;
        logic [31:0] hold_d;
        logic hold_l;
        logic rdy;
        logic [31:0] exp_w;
        check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr[3:0];
        cmd_len   = len[4:0];
        cyc = 0; beats = 0; done_seen = 1'b0; err_early = 1'b0; hold_v = 1'b0;
        hold_d = 32'd0; hold_l = 1'b0;
        @(negedge clk);
        cyc = 1;
        cmd_valid = 1'b0;
        check({tag, " busy_h1"}, {31'd0, busy}, {31'd0, (exp_n > 0)});
        while (!done_seen && cyc < 80) begin
            rdy = toggle ? pat[cyc % 6] : 1'b1;
            out_ready = rdy;
            if (hold_v) begin
                check({tag, " stall_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, " stall_data"}, out_data, hold_d);
                check({tag, " stall_last"}, {31'd0, out_last}, {31'd0, hold_l});
            end
            if (toggle && busy) begin
                ahead = ((int'(RAddr) - addr + 16) % 16) - beats;
                check({tag, " lookahead"}, {31'd0, (ahead <= 3)}, 32'd1);
            end
            if (out_valid && rdy) begin
                exp_w = 32'h100 + 32'((addr + beats) % 16);
                check({tag, " data"}, out_data, exp_w);
                check({tag, " last"}, {31'd0, out_last}, {31'd0, (beats == exp_n - 1)});
                if (!toggle) check({tag, " beat_cycle"}, cyc, 3 + beats);
                beats++;
            end
            hold_v = out_valid && !rdy;
            hold_d = out_data;
            hold_l = out_last;
            if (done) begin
                done_seen = 1'b1;
                check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
                check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
                check({tag, " ready_done"}, {31'd0, cmd_ready}, 32'd1);
                if (!toggle) check({tag, " done_cycle"}, cyc, (exp_n > 0) ? exp_n + 3 : 1);
            end else begin
                if (err) err_early = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done_seen"}, {31'd0, done_seen}, 32'd1);
        check({tag, " beats"}, beats, exp_n);
        check({tag, " err_early"}, {31'd0, err_early}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int nb;
        logic done_seen;
        logic [31:0] exp_q [5];
        logic        exp_lq [5];
        checks = 0;
        errors = 0;
        pat = 6'b101001;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
        RData     = 32'd0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 4'd0;
        cmd_len   = 5'd0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_last",  {31'd0, out_last}, 32'd0);
        check("rst out_data",  out_data, 32'd0);
        check("rst raddr",     {28'd0, RAddr}, 32'd0);
        check("rst busy",      {31'd0, busy}, 32'd0);
        check("rst done",      {31'd0, done}, 32'd0);
        check("rst err",       {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic burst, then same burst with backpressure
        run_burst("b24", 2, 4, 4, 1'b0, 1'b0);
        run_burst("b24bp", 2, 4, 4, 1'b0, 1'b1);

        // Zero length
        run_burst("len0", 5, 0, 0, 1'b0, 1'b0);

        // Full RAM, legal boundary
        run_burst("full", 0, 16, 16, 1'b0, 1'b0);

        // Burst running off the end
`ifdef DPRAM_READER_WRAP_EN
        run_burst("wrap", 14, 4, 4, 1'b0, 1'b0);
        run_burst("clamp", 3, 20, 16, 1'b0, 1'b0);
`else
        run_burst("trunc", 14, 4, 2, 1'b1, 1'b0);
        run_burst("last1", 15, 1, 1, 1'b0, 1'b0);
`endif

        // Reset in cycle h+4 of a len-8 burst
        check("mr cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_len = 5'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("mr out_valid", {31'd0, out_valid}, 32'd0);
        check("mr out_last",  {31'd0, out_last}, 32'd0);
        check("mr out_data",  out_data, 32'd0);
        check("mr raddr",     {28'd0, RAddr}, 32'd0);
        check("mr busy",      {31'd0, busy}, 32'd0);
        check("mr done",      {31'd0, done}, 32'd0);
        check("mr err",       {31'd0, err}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || out_valid) done_seen = 1'b1;
        end
        check("mr quiet", {31'd0, done_seen}, 32'd0);
        run_burst("mr_after", 5, 3, 3, 1'b0, 1'b0);

        // Back-to-back: cmd_valid held, second command waits for cmd_ready
        exp_q[0] = 32'h100; exp_q[1] = 32'h101; exp_q[2] = 32'h102;
        exp_q[3] = 32'h108; exp_q[4] = 32'h109;
        exp_lq[0] = 1'b0; exp_lq[1] = 1'b0; exp_lq[2] = 1'b1;
        exp_lq[3] = 1'b0; exp_lq[4] = 1'b1;
        check("b2b ready0", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_len = 5'd3;
        @(negedge clk);
        cyc = 1; nb = 0; done_seen = 1'b0;
        cmd_addr = 4'd8; cmd_len = 5'd2;
        while (cyc < 40 && !done_seen) begin
            if (cmd_valid && cmd_ready) begin
                check("b2b accept_cycle", cyc, 6);
            end else if (cmd_valid == 1'b1 && cyc > 6) begin
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = cmd_valid;
            end
            if (cyc == 7) cmd_valid = 1'b0;
            if (out_valid) begin
                if (nb < 5) begin
                    check("b2b data", out_data, exp_q[nb]);
                    check("b2b last", {31'd0, out_last}, {31'd0, exp_lq[nb]});
                end
                nb++;
            end
            if (done && cyc == 6) check("b2b done1", {31'd0, done}, 32'd1);
            if (done && cyc > 6) begin
                done_seen = 1'b1;
                check("b2b done2_cycle", cyc, 11);
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b done_seen", {31'd0, done_seen}, 32'd1);
        check("b2b beats", nb, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
